// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Stall/flush controller for the RV32IM 5-stage pipeline. It resolves the
// hazards that forwarding cannot cover: load-use dependencies, the multi-cycle
// divider and taken-branch redirects. It also sequences the divider start pulse
// and keeps saturating stall/flush performance counters.
module hazard_control_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [4:0]           ID_RS1,
    input  logic [4:0]           ID_RS2,
    input  logic                 ID_USES_RS1,
    input  logic                 ID_USES_RS2,
    input  logic [4:0]           EX_RD,
    input  logic                 EX_MemRead,
    input  logic                 EX_IS_DIV,
    input  logic                 MD_DONE,
    input  logic                 BRANCH_TAKEN,
    output logic                 PC_WRITE,
    output logic                 IF_ID_WRITE,
    output logic                 IF_ID_FLUSH,
    output logic                 ID_EX_WRITE,
    output logic                 ID_EX_BUBBLE,
    output logic                 EX_MEM_BUBBLE,
    output logic                 MD_START,
    output logic                 MD_BUSY,
    output logic [CNT_WIDTH-1:0] STALL_CNT,
    output logic [CNT_WIDTH-1:0] FLUSH_CNT
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic div_stall;
    logic load_use;
    logic rs1_match;
    logic rs2_match;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (&value) begin
            return value;
        end
        return value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // State register: divider tracking, cleared immediately on reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: enter MD_WAIT when a divide reaches EX, leave on MD_DONE.
    // MD_DONE while IDLE (including the start cycle) is ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (EX_IS_DIV) state_next = MD_WAIT;
            MD_WAIT: if (MD_DONE)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Hazard detection. Register x0 never creates a load-use dependency.
    assign rs1_match = ID_USES_RS1 && (EX_RD == ID_RS1);
    assign rs2_match = ID_USES_RS2 && (EX_RD == ID_RS2);
    assign load_use  = EX_MemRead && (EX_RD != 5'd0) && (rs1_match || rs2_match);
    assign div_stall = ((state == IDLE) && EX_IS_DIV) || ((state == MD_WAIT) && !MD_DONE);

    // Output logic: div_stall outranks a branch redirect, which outranks load-use
    // (the squashed ID instruction cannot cause a real dependency).
    always_comb begin
        PC_WRITE      = 1'b1;
        IF_ID_WRITE   = 1'b1;
        IF_ID_FLUSH   = 1'b0;
        ID_EX_WRITE   = 1'b1;
        ID_EX_BUBBLE  = 1'b0;
        EX_MEM_BUBBLE = 1'b0;
        if (div_stall) begin
            // Freeze the front of the pipe and hold the divide in EX.
            PC_WRITE      = 1'b0;
            IF_ID_WRITE   = 1'b0;
            ID_EX_WRITE   = 1'b0;
            EX_MEM_BUBBLE = 1'b1;
        end else if (BRANCH_TAKEN) begin
            // PC loads the target; squash the two wrong-path instructions.
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else if (load_use) begin
            // One-cycle hold; the bubble pushes the load out of EX.
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            ID_EX_BUBBLE = 1'b1;
        end
    end

    assign MD_START = (state == IDLE) && EX_IS_DIV && !RESET;
    assign MD_BUSY  = (state == MD_WAIT);

    // Saturating performance counters: stalled-PC cycles and redirect cycles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (!PC_WRITE) begin
                STALL_CNT <= sat_inc(STALL_CNT);
            end
            if (BRANCH_TAKEN) begin
                FLUSH_CNT <= sat_inc(FLUSH_CNT);
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Testbench for hazard_control_unit: table-driven combinational vectors in
// IDLE plus directed multi-cycle sequences (divides, reset, saturation).
module tb_hazard_control_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] ID_RS1, ID_RS2, EX_RD;
    logic       ID_USES_RS1, ID_USES_RS2, EX_MemRead, EX_IS_DIV, MD_DONE, BRANCH_TAKEN;

    logic        pc_write, if_id_write, if_id_flush, id_ex_write;
    logic        id_ex_bubble, ex_mem_bubble, md_start, md_busy;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write;
    logic        s_id_ex_bubble, s_ex_mem_bubble, s_md_start, s_md_busy;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    logic [7:0] outs;
    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write,
                   id_ex_bubble, ex_mem_bubble, md_start, md_busy};

    int checks = 0;
    int fails  = 0;

    always #5 CLK = ~CLK;

    hazard_control_unit #(.CNT_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_RD(EX_RD), .EX_MemRead(EX_MemRead), .EX_IS_DIV(EX_IS_DIV),
        .MD_DONE(MD_DONE), .BRANCH_TAKEN(BRANCH_TAKEN),
        .PC_WRITE(pc_write), .IF_ID_WRITE(if_id_write), .IF_ID_FLUSH(if_id_flush),
        .ID_EX_WRITE(id_ex_write), .ID_EX_BUBBLE(id_ex_bubble),
        .EX_MEM_BUBBLE(ex_mem_bubble), .MD_START(md_start), .MD_BUSY(md_busy),
        .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
    );

    hazard_control_unit #(.CNT_WIDTH(4)) dut_small (
        .CLK(CLK), .RESET(RESET),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_RD(EX_RD), .EX_MemRead(EX_MemRead), .EX_IS_DIV(EX_IS_DIV),
        .MD_DONE(MD_DONE), .BRANCH_TAKEN(BRANCH_TAKEN),
        .PC_WRITE(s_pc_write), .IF_ID_WRITE(s_if_id_write), .IF_ID_FLUSH(s_if_id_flush),
        .ID_EX_WRITE(s_id_ex_write), .ID_EX_BUBBLE(s_id_ex_bubble),
        .EX_MEM_BUBBLE(s_ex_mem_bubble), .MD_START(s_md_start), .MD_BUSY(s_md_busy),
        .STALL_CNT(s_stall_cnt), .FLUSH_CNT(s_flush_cnt)
    );

    // Expected output vector order: PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH,
    // ID_EX_WRITE, ID_EX_BUBBLE, EX_MEM_BUBBLE, MD_START, MD_BUSY.
    localparam logic [7:0] O_RUN   = 8'b1101_0000;
    localparam logic [7:0] O_LU    = 8'b0001_1000;
    localparam logic [7:0] O_BR    = 8'b1111_1000;
    localparam logic [7:0] O_START = 8'b0000_0110;
    localparam logic [7:0] O_WAIT  = 8'b0000_0101;
    localparam logic [7:0] O_DONE  = 8'b1101_0001;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       mem;
        logic       br;
        logic       done;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs just after the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic div, input logic done, input logic br,
                         input logic mem, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        @(negedge CLK);
        EX_IS_DIV    = div;
        MD_DONE      = done;
        BRANCH_TAKEN = br;
        EX_MemRead   = mem;
        EX_RD        = rd;
        ID_RS1       = rs1;
        ID_RS2       = rs2;
        ID_USES_RS1  = u1;
        ID_USES_RS2  = u2;
        #1;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        EX_IS_DIV = 0; MD_DONE = 0; BRANCH_TAKEN = 0; EX_MemRead = 0;
        EX_RD = 0; ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
    endtask

    initial begin
        logic [15:0] base;
        int          starts;
        int          first_start;
        int          second_start;

        RESET = 1'b1;
        EX_IS_DIV = 0; MD_DONE = 0; BRANCH_TAKEN = 0; EX_MemRead = 0;
        EX_RD = 0; ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;

        //               rs1    rs2    u1 u2 rd     mem br done exp
        vecs[0] = '{5'd0,  5'd0,  0, 0, 5'd0,  0,  0, 0,   O_RUN};
        vecs[1] = '{5'd5,  5'd0,  1, 0, 5'd5,  1,  0, 0,   O_LU};
        vecs[2] = '{5'd0,  5'd0,  1, 0, 5'd0,  1,  0, 0,   O_RUN};
        vecs[3] = '{5'd1,  5'd7,  0, 1, 5'd7,  1,  0, 0,   O_LU};
        vecs[4] = '{5'd5,  5'd0,  0, 0, 5'd5,  1,  0, 0,   O_RUN};
        vecs[5] = '{5'd5,  5'd0,  1, 0, 5'd5,  0,  0, 0,   O_RUN};
        vecs[6] = '{5'd0,  5'd0,  0, 0, 5'd0,  0,  1, 0,   O_BR};
        vecs[7] = '{5'd5,  5'd0,  1, 0, 5'd5,  1,  1, 0,   O_BR};
        vecs[8] = '{5'd0,  5'd0,  0, 0, 5'd0,  0,  0, 1,   O_RUN};
        vecs[9] = '{5'd3,  5'd9,  1, 1, 5'd9,  1,  0, 0,   O_LU};

        // Reset state with all inputs low.
        #2;
        check("reset_outs", outs, O_RUN);
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_flush_cnt", flush_cnt, 0);
        @(negedge CLK);
        RESET = 1'b0;

        // Combinational vectors in IDLE.
        for (int i = 0; i < 10; i++) begin
            drive(0, vecs[i].done, vecs[i].br, vecs[i].mem, vecs[i].rd,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2);
            check($sformatf("vec%0d_outs", i), outs, vecs[i].exp);
        end
        idle_in();
        check("vec_stall_cnt", stall_cnt, 3);
        check("vec_flush_cnt", flush_cnt, 2);

        // Single load-use: counter 0 -> 1, then released.
        do_reset();
        drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("lu_outs", outs, O_LU);
        idle_in();
        check("lu_release", outs, O_RUN);
        check("lu_stall_cnt", stall_cnt, 1);

        // Branch with concurrent load-use: flush wins, stall count unchanged.
        drive(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("br_lu_outs", outs, O_BR);
        idle_in();
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 1);

        // Divide, N=4. MD_DONE in the start cycle must be ignored.
        do_reset();
        drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("div4_c0", outs, O_START);
        for (int k = 1; k < 4; k++) begin
            drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            check($sformatf("div4_c%0d", k), outs, O_WAIT);
        end
        drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("div4_done", outs, O_DONE);
        idle_in();
        check("div4_after", outs, O_RUN);
        check("div4_stall_cnt", stall_cnt, 4);

        // Back-to-back divides, N=2 each.
        base = stall_cnt;
        starts = 0;
        first_start = -1;
        second_start = -1;
        for (int k = 0; k < 6; k++) begin
            drive(1, (k == 2 || k == 5), 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            if (md_start) begin
                starts++;
                if (first_start < 0) first_start = k;
                else second_start = k;
            end
            check($sformatf("b2b_c%0d", k), outs,
                  (k == 0 || k == 3) ? O_START : ((k == 2 || k == 5) ? O_DONE : O_WAIT));
        end
        idle_in();
        check("b2b_starts", starts, 2);
        check("b2b_spacing", second_start - first_start, 3);
        check("b2b_stall_delta", stall_cnt - base, 4);

        // Reset two cycles after MD_START, then MD_DONE.
        drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("rst_div_start", md_start, 1);
        drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        @(negedge CLK);
        RESET = 1'b1;
        EX_IS_DIV = 0;
        #1;
        check("rst_mid_outs", outs, O_RUN);
        check("rst_mid_stall_cnt", stall_cnt, 0);
        drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("rst_done_outs", outs, O_RUN);
        drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("rst_no_start", md_start, 0);
        @(negedge CLK);
        RESET = 1'b0;
        EX_IS_DIV = 0;
        MD_DONE = 1;
        #1;
        check("rst_after_done", outs, O_RUN);
        idle_in();
        check("rst_after_busy", md_busy, 0);
        check("rst_after_stall_cnt", stall_cnt, 0);
        check("rst_after_flush_cnt", flush_cnt, 0);

        // Saturation on the 4-bit instance: 20 load-use cycles.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        end
        idle_in();
        check("sat_small_stall_cnt", s_stall_cnt, 15);
        check("sat_wide_stall_cnt", stall_cnt, 20);
        drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        idle_in();
        check("sat_small_hold", s_stall_cnt, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
